// File: rtl/c3po_cfg_regfile.sv
// ---------------------------------------------------------------------------
// c3po_cfg_regfile
//
// Per-port control/status register block for the C-3PO controllers. It
// decodes a simple req/rd_wr/addr host bus into PORTS_P identical register
// slices plus one global ID register. Every access gets a registered ack
// exactly one cycle after the request. The read data and the error response
// travel with that ack.
//
// Slice i occupies addresses ADDR_STRIDE_P*i + {0,1,2}:
//   +0 CTRL    (RW)  [0] enable, [7:4] port_id
//   +1 STATUS        [0] idle (live input), [1] err_sticky (write 1 to clear)
//   +2 ERR_CNT (RO)  saturating error-event counter, cleared by a read
// The ID register sits at PORTS_P*ADDR_STRIDE_P. All other addresses are
// unmapped. Accesses to them complete with resp_err=1 and read_val=0.
//
// Ports:
//   clk, reset_L        clock (rising edge) / asynchronous active-low reset
//   req, rd_wr, addr    access request, 1=read 0=write, word address
//   write_val           write data
//   read_val, ack       read data (0 unless ack) and one-cycle completion
//   resp_err            with ack: the access targeted an unmapped address
//   cfg_ctrl_err        per-port error level from the controllers
//   cfg_ctrl_idle       per-port idle level from the controllers
//   cfg_port_enable     per-port enable (CTRL[0])
//   cfg_port_id         per-port 4-bit ID (CTRL[7:4])
// ---------------------------------------------------------------------------
module c3po_cfg_regfile #(
  parameter int unsigned PORTS_P       = 4,
  parameter int unsigned ADDR_SIZE_P   = 6,
  parameter int unsigned ADDR_STRIDE_P = 4,
  parameter int unsigned ERR_CNT_W_P   = 8,
  parameter logic [7:0]  VERSION_P     = 8'h02
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     req,
  input  logic                     rd_wr,
  input  logic [ADDR_SIZE_P-1:0]   addr,
  input  logic [31:0]              write_val,
  output logic [31:0]              read_val,
  output logic                     ack,
  output logic                     resp_err,
  input  logic [PORTS_P-1:0]       cfg_ctrl_err,
  input  logic [PORTS_P-1:0]       cfg_ctrl_idle,
  output logic [PORTS_P-1:0]       cfg_port_enable,
  output logic [PORTS_P-1:0][3:0]  cfg_port_id
);

  localparam logic [ADDR_SIZE_P-1:0] ID_ADDR  = ADDR_SIZE_P'(PORTS_P * ADDR_STRIDE_P);
  localparam logic [31:0]            ID_VAL   = {16'hC3C0, 8'(PORTS_P), VERSION_P};
  localparam logic [ERR_CNT_W_P-1:0] CNT_MAX  = '1;
  localparam logic [ERR_CNT_W_P-1:0] CNT_ONE  = ERR_CNT_W_P'(1);

  // Qualified bus strobes
  logic rd_req;
  logic wr_req;
  assign rd_req = req & rd_wr;
  assign wr_req = req & ~rd_wr;

  // Per-slice address hits and read contributions. At most one hit is active
  // at a time, so the slice read data can simply be OR-combined.
  logic [PORTS_P-1:0]       hit_ctrl;
  logic [PORTS_P-1:0]       hit_stat;
  logic [PORTS_P-1:0]       hit_cnt;
  logic [PORTS_P-1:0][31:0] slice_rdata;
  logic                     hit_id;
  logic                     mapped;

  // Only CTRL[0], STATUS[1] and CTRL[7:4] are writable; the rest of the
  // write word is intentionally ignored.
  logic unused_write_bits;
  assign unused_write_bits = ^{write_val[31:8], write_val[3:2]};

  // -------------------------------------------------------------------------
  // Register slices
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < PORTS_P; gi++) begin : g_slice
    localparam int unsigned BASE = gi * ADDR_STRIDE_P;

    logic                   enable_q;
    logic                   enable_d;
    logic [3:0]             id_q;
    logic [3:0]             id_d;
    logic                   sticky_q;
    logic                   sticky_d;
    logic [ERR_CNT_W_P-1:0] cnt_q;
    logic [ERR_CNT_W_P-1:0] cnt_d;
    logic                   err_prev_q;
    logic                   err_event;
    logic                   cnt_clr;
    logic                   sticky_clr;

    assign hit_ctrl[gi] = (addr == ADDR_SIZE_P'(BASE));
    assign hit_stat[gi] = (addr == ADDR_SIZE_P'(BASE + 1));
    assign hit_cnt[gi]  = (addr == ADDR_SIZE_P'(BASE + 2));

    // Rising edge of the error level, counted only while the port is
    // enabled. The enable used here is the pre-write value, so an error edge
    // coinciding with a disabling CTRL write still counts.
    assign err_event  = cfg_ctrl_err[gi] & ~err_prev_q & enable_q;
    assign cnt_clr    = rd_req & hit_cnt[gi];
    assign sticky_clr = wr_req & hit_stat[gi] & write_val[1];

    always_comb begin
      enable_d = enable_q;
      id_d     = id_q;
      if (wr_req && hit_ctrl[gi]) begin
        enable_d = write_val[0];
        id_d     = write_val[7:4];
      end

      // A new event beats a simultaneous write-1-to-clear.
      sticky_d = sticky_q;
      if (err_event) begin
        sticky_d = 1'b1;
      end else if (sticky_clr) begin
        sticky_d = 1'b0;
      end

      // A read returns the pre-event count; an event in the same cycle
      // leaves exactly one count behind.
      cnt_d = cnt_q;
      if (err_event) begin
        if (cnt_clr) begin
          cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (cnt_clr) begin
        cnt_d = '0;
      end
    end

    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        enable_q   <= 1'b0;
        id_q       <= 4'(gi);
        sticky_q   <= 1'b0;
        cnt_q      <= '0;
        err_prev_q <= 1'b0;
      end else begin
        enable_q   <= enable_d;
        id_q       <= id_d;
        sticky_q   <= sticky_d;
        cnt_q      <= cnt_d;
        err_prev_q <= cfg_ctrl_err[gi];
      end
    end

    assign slice_rdata[gi] = hit_ctrl[gi] ? {24'h0, id_q, 3'b000, enable_q} :
                             hit_stat[gi] ? {30'h0, sticky_q, cfg_ctrl_idle[gi]} :
                             hit_cnt[gi]  ? 32'(cnt_q) :
                                            32'h0;

    assign cfg_port_enable[gi] = enable_q;
    assign cfg_port_id[gi]     = id_q;
  end : g_slice

  // -------------------------------------------------------------------------
  // Global decode and registered response
  // -------------------------------------------------------------------------
  assign hit_id = (addr == ID_ADDR);
  assign mapped = hit_id | (|hit_ctrl) | (|hit_stat) | (|hit_cnt);

  logic [31:0] rdata_mux;
  logic        ack_d;
  logic        ack_q;
  logic        resp_err_d;
  logic        resp_err_q;
  logic [31:0] read_val_d;
  logic [31:0] read_val_q;

  always_comb begin
    rdata_mux = hit_id ? ID_VAL : 32'h0;
    for (int i = 0; i < int'(PORTS_P); i++) begin
      rdata_mux = rdata_mux | slice_rdata[i];
    end

    ack_d      = req;
    resp_err_d = req & ~mapped;
    // Data is only driven for mapped reads; writes and errors return 0.
    read_val_d = (rd_req && mapped) ? rdata_mux : 32'h0;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ack_q      <= 1'b0;
      resp_err_q <= 1'b0;
      read_val_q <= 32'h0;
    end else begin
      ack_q      <= ack_d;
      resp_err_q <= resp_err_d;
      read_val_q <= read_val_d;
    end
  end

  assign ack      = ack_q;
  assign resp_err = resp_err_q;
  assign read_val = read_val_q;

endmodule : c3po_cfg_regfile

// File: doc/c3po_cfg_regfile.md
Name: c3po_cfg_regfile

Overview:
- Parametrised successor to the C-3PO per-port control register block.
- Decodes a single req/rd_wr/addr bus into PORTS_P register slices, each holding:
  - a CTRL register (enable, port ID);
  - a STATUS register (live idle, sticky error);
  - a saturating clear-on-read error-event counter.
- Adds a registered one-cycle ack, an error response for unmapped addresses, and a global ID register.
- Sits between the host config bus and the per-port C-3PO controllers.

Parameters:
- PORTS_P, 4: number of port slices (1..16).
- ADDR_SIZE_P, 6: address width; must satisfy 2^ADDR_SIZE_P > PORTS_P*ADDR_STRIDE_P.
- ADDR_STRIDE_P, 4: address distance between slices (>=3).
- ERR_CNT_W_P, 8: error counter width (1..32).
- VERSION_P, 8'h02: value reported in the ID register.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- req  in  1  access request, one access per cycle in which it is high.
- rd_wr  in  1  1 = read, 0 = write.
- addr  in  ADDR_SIZE_P  word address.
- write_val  in  32  write data.
- read_val  out  32  read data, valid when ack=1.
- ack  out  1  access complete.
- resp_err  out  1  with ack: access hit an unmapped address.
- cfg_ctrl_err  in  PORTS_P  per-port error indication (level).
- cfg_ctrl_idle  in  PORTS_P  per-port idle indication (level).
- cfg_port_enable  out  PORTS_P  per-port enable.
- cfg_port_id  out  PORTS_P x 4  per-port ID.

Behaviour:
- Address map: slice i base B = ADDR_STRIDE_P*i.
  - B+0 CTRL (RW): [0] enable, [7:4] port_id; other bits read 0.
  - B+1 STATUS: [0] idle (RO, live cfg_ctrl_idle[i] sampled on the request cycle), [1] err_sticky (W1C); other bits read 0.
  - B+2 ERR_CNT (RO, clear-on-read): [ERR_CNT_W_P-1:0].
  - Offsets 3..ADDR_STRIDE_P-1 are unmapped.
  - ID register (RO) at PORTS_P*ADDR_STRIDE_P, value {16'hC3C0, 8'(PORTS_P), VERSION_P}.
  - Every other address is unmapped.
- Handshake: a req seen high at edge N produces ack=1 for exactly cycle N+1.
  - read_val and resp_err are registered alongside ack and held 0 when ack=0.
  - Back-to-back reqs are legal: ack stays high on consecutive cycles, each carrying its own access.
  - No backpressure.
- Writes update the register at the same edge that samples req.
  - Writes to RO registers or unmapped addresses change nothing.
  - Unmapped accesses (read or write) return ack=1, resp_err=1, read_val=0.
  - Mapped accesses return resp_err=0.
- Error edge detect: per port, a registered copy of cfg_ctrl_err.
  - An event is a 0->1 transition while cfg_port_enable[i]=1.
  - An event sets err_sticky and increments ERR_CNT, saturating at 2^ERR_CNT_W_P-1 with no wrap.
- Simultaneous events:
  - W1C of err_sticky in the same cycle as an event: sticky stays 1 (set wins).
  - ERR_CNT read in the same cycle as an event: read returns the pre-event value and the counter becomes 1.
  - A read without an event clears the counter to 0.
  - A write to CTRL that disables a port in the same cycle as an error edge: the event counts (enable sampled pre-write).
- Reset values (reset_L=0, asynchronous):
  - ack=0, resp_err=0, read_val=0.
  - cfg_port_enable=0; cfg_port_id[i]=i[3:0].
  - err_sticky=0, ERR_CNT=0, edge-detect flops=0.
- Reset mid-access: any pending ack is dropped, with no ack after reset release for a req sampled before reset.

Test Plan:
- Reset defaults: PORTS_P=4, STRIDE=4.
  - After reset, read addr 0,4,8,12 -> read_val 32'h00/10/20/30; cfg_port_id={3,2,1,0}; cfg_port_enable=0.
  - Read addr 16 -> 32'hC3C0_0402.
- CTRL write/read: write addr 4 = 32'h0000_00A1 -> next cycle cfg_port_enable[1]=1, cfg_port_id[1]=4'hA.
  - Read addr 4 -> 32'h0000_00A1, ack exactly 1 cycle after req.
- Error counting: enable port 2, pulse cfg_ctrl_err[2] three times.
  - Read addr 9 -> bit1=1.
  - Read addr 10 -> 3; read again -> 0.
  - With the port disabled, pulses -> count stays 0.
- Saturation and W1C race: ERR_CNT_W_P=2, five edges -> count 3.
  - Write addr 9 = 32'h2 in the same cycle as a new edge -> sticky remains 1.
  - ERR_CNT read coinciding with an edge -> returns 3, next read returns 1.
- Unmapped access: read addr 3 and addr 20 -> ack=1, resp_err=1, read_val=0.
  - Write addr 3 -> no register changes.
- Back-to-back and reset mid-access: req high 4 cycles to addrs 0,4,8,12 -> ack high 4 consecutive cycles with matching data.
  - Assert reset_L=0 the cycle after a req -> ack=0 and stays 0 after release.
